// File: rtl/csr_controller.sv
// Machine-mode CSR file: mie, mtvec, mscratch, mepc, mcause.
// Combinational read, RW/RS/RC update, trap capture of mepc/mcause.
package csr_pkg;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;
endpackage

module csr_controller
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trap_i,
  input  logic            write_enable_i,
  input  logic [2:0]      opcode_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] imm_data_i,
  output logic [XLEN-1:0] read_data_o,
  output logic [XLEN-1:0] mie_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic            hit;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;
  logic            wr_en;

  // Address decode and read mux; unmapped addresses read zero
  always_comb begin
    hit     = 1'b1;
    old_val = '0;
    unique case (addr_i)
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      default:      hit     = 1'b0;
    endcase
  end

  assign read_data_o = old_val;

  // Operand select and read-modify-write value
  always_comb begin
    operand = opcode_i[2] ? imm_data_i : rs1_data_i;
    new_val = old_val;
    unique case (opcode_i[1:0])
      OP_RW:   new_val = operand;
      OP_RS:   new_val = old_val | operand;
      OP_RC:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
  end

  assign wr_en = write_enable_i && (opcode_i[1:0] != OP_NONE)
              && hit && !trap_i;

  // Next-state: a trap captures mepc/mcause and blocks instruction writes
  always_comb begin
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_i) begin
      mepc_d   = pc_i;
      mcause_d = mcause_i;
    end else if (wr_en) begin
      unique case (addr_i)
        CSR_MIE:      mie_d      = new_val;
        CSR_MTVEC:    mtvec_d    = new_val;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val;
        CSR_MCAUSE:   mcause_d   = new_val;
        default:      ;
      endcase
    end
  end

  // CSR state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mie_o   = mie_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_controller.sv
// Scoreboard bench for csr_controller.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_csr_controller;
  logic        clk;
  logic        rst;
  logic        trap;
  logic        we;
  logic [2:0]  opc;
  logic [11:0] addr;
  logic [31:0] pc, cause, rs1, imm;
  logic [31:0] rdata, mie, mtvec, mepc;

  csr_controller #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .trap_i(trap),
    .write_enable_i(we), .opcode_i(opc), .addr_i(addr),
    .pc_i(pc), .mcause_i(cause),
    .rs1_data_i(rs1), .imm_data_i(imm),
    .read_data_o(rdata), .mie_o(mie),
    .mtvec_o(mtvec), .mepc_o(mepc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] got(int sel);
    case (sel)
      0: return rdata;
      1: return mie;
      2: return mtvec;
      default: return mepc;
    endcase
  endfunction

  // Monitor: pop and compare every expectation due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      checks++;
      a = got(e.sel);
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale expectation cyc %0d now %0d",
                 e.name, e.cyc, cyc);
      end else if (a !== e.val) begin
        errors++;
        $display("FAIL %s got %h expected %h", e.name, a, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] o,
                       input logic [11:0] a, input logic [31:0] r,
                       input logic [31:0] i);
    we = w; opc = o; addr = a; rs1 = r; imm = i;
    trap = 0; pc = 0; cause = 0;
  endtask

  task automatic expect_v(input int sel, input logic [31:0] v,
                          input string n);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  localparam logic [11:0] A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MSCR = 12'h340, A_MEPC = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342, A_BAD = 12'h300;

  logic [11:0] addrs [5] = '{A_MIE, A_MTVEC, A_MSCR, A_MEPC, A_MCAUSE};

  initial begin
    rst = 1;
    drive(0, 3'b000, 12'h0, 0, 0);
    repeat (2) tick();
    rst = 0;

    // preload every CSR with all ones
    for (int k = 0; k < 5; k++) begin
      drive(1, 3'b001, addrs[k], 32'hFFFF_FFFF, 0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 3'b001, addrs[k], 0, 0);
      expect_v(0, 32'hFFFF_FFFF, "preload");
      tick();
    end

    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 3'b000, addrs[k], 0, 0);
      expect_v(0, 32'h0, "reset_read");
      tick();
    end
    expect_v(1, 32'h0, "reset_mie");
    expect_v(2, 32'h0, "reset_mtvec");
    expect_v(3, 32'h0, "reset_mepc");

    // RW/RS/RC on mscratch
    drive(1, 3'b001, A_MSCR, 32'h0000_F0F0, 0);
    expect_v(0, 32'h0, "rw_old");
    tick();
    drive(1, 3'b010, A_MSCR, 32'h0F00_0000, 0);
    expect_v(0, 32'h0000_F0F0, "rs_old");
    tick();
    drive(1, 3'b011, A_MSCR, 32'h0000_00F0, 0);
    expect_v(0, 32'h0F00_F0F0, "rc_old");
    tick();
    drive(1, 3'b010, A_MSCR, 32'h0, 0);
    expect_v(0, 32'h0F00_F000, "rc_new");
    tick();
    drive(0, 3'b000, A_MSCR, 0, 0);
    expect_v(0, 32'h0F00_F000, "rs_zero");
    tick();

    // immediate ops on mie
    drive(1, 3'b101, A_MIE, 32'hFFFF_FFFF, 32'h1F);
    expect_v(0, 32'h0, "rwi_old");
    expect_v(1, 32'h0, "rwi_mie");
    tick();
    drive(1, 3'b111, A_MIE, 32'hFFFF_FFFF, 32'h03);
    expect_v(0, 32'h1F, "rci_old");
    expect_v(1, 32'h1F, "rci_mie");
    tick();
    drive(1, 3'b110, A_MIE, 32'h0, 32'h01);
    expect_v(0, 32'h1C, "rsi_old");
    expect_v(1, 32'h1C, "rsi_mie");
    tick();
    drive(0, 3'b000, A_MIE, 0, 0);
    expect_v(0, 32'h1D, "rsi_new");
    expect_v(1, 32'h1D, "rsi_mie_new");
    tick();

    // trap suppresses mtvec write, captures mepc/mcause
    drive(1, 3'b001, A_MTVEC, 32'h100, 0);
    tick();
    drive(1, 3'b001, A_MTVEC, 32'h200, 0);
    trap = 1; pc = 32'h8000_0040; cause = 32'h8000_0007;
    expect_v(0, 32'h100, "trap_old");
    expect_v(3, 32'h0, "trap_mepc_old");
    tick();
    drive(0, 3'b000, A_MCAUSE, 0, 0);
    expect_v(0, 32'h8000_0007, "trap_mcause");
    expect_v(3, 32'h8000_0040, "trap_mepc");
    expect_v(2, 32'h100, "trap_mtvec");
    expect_v(1, 32'h1D, "trap_mie");
    tick();

    // trap beats mepc write
    drive(1, 3'b001, A_MEPC, 32'h1234, 0);
    trap = 1; pc = 32'h50; cause = 32'h3;
    tick();
    drive(1, 3'b001, A_MEPC, 32'h1234, 0);
    expect_v(0, 32'h50, "trap_vs_write");
    expect_v(3, 32'h50, "trap_vs_write_o");
    tick();
    drive(0, 3'b000, A_MEPC, 0, 0);
    expect_v(0, 32'h1234, "mepc_write");
    expect_v(3, 32'h1234, "mepc_write_o");
    tick();

    // unmapped and invalid
    drive(1, 3'b001, A_BAD, 32'hDEAD, 0);
    expect_v(0, 32'h0, "unmapped_rd");
    tick();
    drive(0, 3'b000, A_BAD, 0, 0);
    expect_v(0, 32'h0, "unmapped_rd2");
    tick();
    drive(1, 3'b100, A_MSCR, 32'hFFFF_FFFF, 32'h1F);
    expect_v(0, 32'h0F00_F000, "op100_old");
    tick();
    drive(1, 3'b000, A_MSCR, 32'hFFFF_FFFF, 32'h1F);
    expect_v(0, 32'h0F00_F000, "op100_after");
    tick();
    drive(0, 3'b001, A_MSCR, 32'h1111_1111, 0);
    expect_v(0, 32'h0F00_F000, "op000_after");
    tick();
    drive(0, 3'b000, A_MSCR, 0, 0);
    expect_v(0, 32'h0F00_F000, "we0_after");
    expect_v(1, 32'h1D, "final_mie");
    expect_v(2, 32'h100, "final_mtvec");
    expect_v(3, 32'h1234, "final_mepc");
    tick();

    repeat (3) tick();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never checked got none expected %h",
               e.name, e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
